// File: rtl/ltc2308_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ltc2308_pkg
// Description : Shared types and constants for the LTC2308 responder model:
//               FSM state encoding, config word layout and channel decode.
// Revision    : 1.0 - initial release
// ============================================================================
package ltc2308_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  // Config word {SD,OS,S1,S0,UNI,SLP}, shifted in MSB first
  localparam int CFG_W = 6;
  localparam logic [CFG_W-1:0] RESET_CFG = 6'b100010;  // CH0, single-ended, unipolar

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Channel select is {S1,S0,OS}; the odd/sign bit is the channel LSB
  function automatic logic [2:0] cfg_to_channel(input logic [CFG_W-1:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-flop synchronizer for an asynchronous pin with
//               single-cycle rise/fall pulses on the synchronized copy.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/ltc2308_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : ltc2308_adc_responder
// Description : Synthesizable LTC2308 SPI ADC slave model. Takes the config
//               word on SDI, models conversion time, returns a 12-bit sample
//               from one of 8 parallel channel inputs on SDO and flags
//               master protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module ltc2308_adc_responder
  import ltc2308_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                convst,
  input  logic                sck,
  input  logic                sdi,
  output logic                sdo,
  input  logic [8*DATA_W-1:0] ch_value,
  output logic                busy,
  output logic [15:0]         conv_count,
  output logic [CFG_W-1:0]    active_cfg,
  output logic                proto_err
);

  localparam int                 c_tmr_w    = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [c_tmr_w-1:0] c_tmr_load = c_tmr_w'(CONV_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
  localparam int                 c_bit_w    = $clog2(DATA_W + 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
  localparam logic [2:0]         c_cfg_full = 3'(CFG_W);
  localparam logic [2:0]         c_cfg_one  = 3'd1;

  // Synchronized pin views
  logic w_convst_level, w_convst_rise, w_convst_fall;
  logic w_sck_rise, w_sck_fall;
  logic w_sdi_level;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_convst (
    .clk(clk), .reset(reset), .i_din(convst),
    .o_level(w_convst_level), .o_rise(w_convst_rise), .o_fall(w_convst_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .i_din(sck),
    .o_level(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .i_din(sdi),
    .o_level(w_sdi_level), .o_rise(), .o_fall()
  );

  // Registered state
  state_t             r_state;
  logic [c_tmr_w-1:0] r_timer;
  logic [DATA_W-1:0]  r_shreg;
  logic               r_sdo;
  logic               r_busy;
  logic [15:0]        r_conv_count;
  logic [CFG_W-1:0]   r_active_cfg;
  logic [CFG_W-1:0]   r_pending_cfg;
  logic [2:0]         r_cfg_cnt;
  logic [c_bit_w-1:0] r_bit_cnt;
  logic               r_proto_err;

  // Next-state values
  state_t             w_state_nxt;
  logic [c_tmr_w-1:0] w_timer_nxt;
  logic [DATA_W-1:0]  w_shreg_nxt;
  logic               w_sdo_nxt;
  logic               w_busy_nxt;
  logic [15:0]        w_conv_count_nxt;
  logic [CFG_W-1:0]   w_active_cfg_nxt;
  logic [CFG_W-1:0]   w_pending_cfg_nxt;
  logic [2:0]         w_cfg_cnt_nxt;
  logic [c_bit_w-1:0] w_bit_cnt_nxt;
  logic               w_proto_err_nxt;

  // Result mux: selected channel, optionally offset to two's complement
  logic [2:0]        w_ch;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_result;

  assign w_ch     = cfg_to_channel(r_active_cfg);
  assign w_raw    = ch_value[int'(w_ch)*DATA_W +: DATA_W];
  assign w_result = r_active_cfg[CFG_UNI] ? w_raw
                                          : {~w_raw[DATA_W-1], w_raw[DATA_W-2:0]};

  // Next-state logic; a convst rise outside CONV overrides any same-cycle shift
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_shreg_nxt       = r_shreg;
    w_sdo_nxt         = r_sdo;
    w_busy_nxt        = r_busy;
    w_conv_count_nxt  = r_conv_count;
    w_active_cfg_nxt  = r_active_cfg;
    w_pending_cfg_nxt = r_pending_cfg;
    w_cfg_cnt_nxt     = r_cfg_cnt;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_proto_err_nxt   = r_proto_err;

    case (r_state)
      ST_CONV: begin
        if (w_convst_rise || w_sck_rise || w_sck_fall) begin
          w_proto_err_nxt = 1'b1;
        end
        if (r_timer == '0) begin
          w_shreg_nxt      = w_result;
          w_sdo_nxt        = w_result[DATA_W-1];
          w_busy_nxt       = 1'b0;
          w_conv_count_nxt = r_conv_count + 16'd1;
          w_state_nxt      = w_convst_level ? ST_READY : ST_SHIFT;
        end else begin
          w_timer_nxt = r_timer - c_tmr_one;
        end
      end
      ST_READY: begin
        if (!w_convst_level) begin
          w_state_nxt = ST_SHIFT;
          w_sdo_nxt   = r_shreg[DATA_W-1];
        end
      end
      ST_SHIFT: begin
        // Past the last data bit the register is all zeros, so sdo stays 0
        if (w_sck_fall && (r_bit_cnt < c_bit_last)) begin
          w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
          w_sdo_nxt     = r_shreg[DATA_W-2];
          w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
        end
        if (w_sck_rise && (r_cfg_cnt < c_cfg_full)) begin
          w_pending_cfg_nxt = {r_pending_cfg[CFG_W-2:0], w_sdi_level};
          w_cfg_cnt_nxt     = r_cfg_cnt + c_cfg_one;
        end
      end
      default: ;
    endcase

    if (w_convst_rise && (r_state != ST_CONV)) begin
      w_state_nxt       = ST_CONV;
      w_busy_nxt        = 1'b1;
      w_timer_nxt       = c_tmr_load;
      w_shreg_nxt       = r_shreg;
      w_sdo_nxt         = r_sdo;
      w_pending_cfg_nxt = r_pending_cfg;
      if (r_cfg_cnt == c_cfg_full) begin
        w_active_cfg_nxt = r_pending_cfg;
      end
      w_cfg_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_shreg       <= '0;
      r_sdo         <= 1'b0;
      r_busy        <= 1'b0;
      r_conv_count  <= '0;
      r_active_cfg  <= RESET_CFG;
      r_pending_cfg <= RESET_CFG;
      r_cfg_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_shreg       <= w_shreg_nxt;
      r_sdo         <= w_sdo_nxt;
      r_busy        <= w_busy_nxt;
      r_conv_count  <= w_conv_count_nxt;
      r_active_cfg  <= w_active_cfg_nxt;
      r_pending_cfg <= w_pending_cfg_nxt;
      r_cfg_cnt     <= w_cfg_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_proto_err   <= w_proto_err_nxt;
    end
  end

  assign sdo        = r_sdo;
  assign busy       = r_busy;
  assign conv_count = r_conv_count;
  assign active_cfg = r_active_cfg;
  assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_ltc2308_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltc2308_adc_responder
// Description : Directed self-checking bench for the LTC2308 responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltc2308_adc_responder;

  logic        clk;
  logic        reset;
  logic        convst;
  logic        sck;
  logic        sdi;
  logic        sdo;
  logic [95:0] ch_value;
  logic        busy;
  logic [15:0] conv_count;
  logic [5:0]  active_cfg;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  ltc2308_adc_responder #(
    .CONV_CYCLES(80),
    .SYNC_STAGES(2),
    .DATA_W(12)
  ) dut (
    .clk(clk), .reset(reset), .convst(convst), .sck(sck), .sdi(sdi),
    .sdo(sdo), .ch_value(ch_value), .busy(busy), .conv_count(conv_count),
    .active_cfg(active_cfg), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected ADC word from a config word and a channel snapshot
  function automatic logic [11:0] model(input logic [5:0] cfg, input logic [95:0] chv);
    int          ch;
    logic [11:0] v;
    ch = int'(cfg[3]) * 4 + int'(cfg[2]) * 2 + int'(cfg[4]);
    v  = chv[ch*12 +: 12];
    if (cfg[1] == 1'b0) v = v ^ 12'h800;
    return v;
  endfunction

  // convst pulse of 'hold' cycles, optional second rise; counts busy cycles
  task automatic do_conv(input int hold, input int glitch_at, output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    busy_cycles = 0;
    @(negedge clk);
    convst = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == hold) convst = 1'b0;
      if (glitch_at > 0 && k == glitch_at) convst = 1'b1;
      if (glitch_at > 0 && k == glitch_at + 2) convst = 1'b0;
      if (busy === 1'b1) begin
        busy_cycles++;
        seen = 1'b1;
      end else if (seen && k > hold) begin
        break;
      end
    end
    convst = 1'b0;
  endtask

  // Master read: sample sdo, present sdi, pulse sck (14 clk per bit)
  task automatic read_bits(input int nbits, input logic [5:0] word, output logic [15:0] data);
    data = '0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      data = {data[14:0], sdo};
      sdi  = (i < 6) ? word[5-i] : 1'b0;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
      repeat (5) @(negedge clk);
    end
    sdi = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          bc;
    logic [15:0] d;
    logic [5:0]  next_cfg;
    logic [5:0]  cur_cfg;
    logic [5:0]  word;
    logic [95:0] snap;

    reset    = 1'b1;
    convst   = 1'b0;
    sck      = 1'b0;
    sdi      = 1'b0;
    ch_value = '0;
    repeat (3) @(negedge clk);
    check("rst_sdo", 32'(sdo), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(conv_count), 32'h0);
    check("rst_cfg", 32'(active_cfg), 32'h22);
    check("rst_perr", 32'(proto_err), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // First conversion on CH0
    ch_value[0 +: 12] = 12'hABC;
    do_conv(2, 0, bc);
    check("t1_busy_len", 32'(bc), 32'd80);
    check("t1_count", 32'(conv_count), 32'd1);
    check("t1_cfg", 32'(active_cfg), 32'h22);
    read_bits(12, 6'b100010, d);
    check("t1_data", 32'(d[11:0]), 32'hABC);

    // Config for CH5 bipolar shifted in during read 2 applies to conversion 3
    ch_value[60 +: 12] = 12'h123;
    do_conv(2, 0, bc);
    read_bits(12, 6'b111000, d);
    check("t2_read2_ch0", 32'(d[11:0]), 32'hABC);
    check("t2_cfg2", 32'(active_cfg), 32'h22);
    do_conv(2, 0, bc);
    check("t2_cfg3", 32'(active_cfg), 32'h38);
    read_bits(12, 6'b111000, d);
    check("t2_read3", 32'(d[11:0]), 32'h923);

    // Second convst rise mid-conversion
    check("t3_perr_before", 32'(proto_err), 32'h0);
    do_conv(2, 23, bc);
    check("t3_busy_len", 32'(bc), 32'd80);
    check("t3_perr", 32'(proto_err), 32'h1);
    check("t3_count", 32'(conv_count), 32'd4);

    // 16 sck clocks: bits 13..16 are zero
    read_bits(16, 6'b111000, d);
    check("t4_16bit", 32'(d), 32'h9230);

    // Partial 4-bit config word must not take effect
    do_conv(2, 0, bc);
    read_bits(4, 6'b100010, d);
    check("t4_partial_bits", 32'(d[3:0]), 32'h9);
    ch_value[60 +: 12] = 12'h7FF;
    do_conv(2, 0, bc);
    check("t4_cfg_kept", 32'(active_cfg), 32'h38);
    ch_value[60 +: 12] = 12'h000;
    read_bits(12, 6'b100010, d);
    check("t4_sampled_at_end", 32'(d[11:0]), 32'hFFF);
    check("t4_count", 32'(conv_count), 32'd6);

    // convst held past conversion end (READY path)
    do_conv(100, 0, bc);
    check("t5_busy_len", 32'(bc), 32'd80);
    check("t5_cfg", 32'(active_cfg), 32'h22);
    read_bits(12, 6'b100010, d);
    check("t5_data", 32'(d[11:0]), 32'hABC);
    check("t5_perr_sticky", 32'(proto_err), 32'h1);

    // Reset in the middle of a read
    do_conv(2, 0, bc);
    read_bits(5, 6'b100010, d);
    check("t6_partial", 32'(d[4:0]), 32'h15);
    #3 reset = 1'b1;
    #1;
    check("t6_sdo", 32'(sdo), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_count", 32'(conv_count), 32'h0);
    check("t6_cfg", 32'(active_cfg), 32'h22);
    check("t6_perr", 32'(proto_err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    ch_value[0 +: 12] = 12'h5A5;
    do_conv(2, 0, bc);
    check("t6_after_count", 32'(conv_count), 32'd1);
    check("t6_after_cfg", 32'(active_cfg), 32'h22);
    read_bits(12, 6'b100010, d);
    check("t6_after_data", 32'(d[11:0]), 32'h5A5);

    // Random back-to-back transactions with random config words
    next_cfg = 6'b100010;
    cur_cfg  = next_cfg;
    for (int n = 0; n < 25; n++) begin
      for (int c = 0; c < 8; c++) ch_value[c*12 +: 12] = 12'($urandom);
      snap    = ch_value;
      cur_cfg = next_cfg;
      do_conv(2, 0, bc);
      ch_value = {$urandom, $urandom, $urandom};
      word     = 6'($urandom);
      read_bits(12, word, d);
      check($sformatf("soak%0d", n), 32'(d[11:0]), 32'(model(cur_cfg, snap)));
      next_cfg = word;
    end
    check("soak_count", 32'(conv_count), 32'd26);
    check("soak_cfg", 32'(active_cfg), 32'(cur_cfg));
    check("soak_perr", 32'(proto_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
